// File: rtl/ccff_loader.sv
// ccff_loader: streams a byte bitstream into a ccff chain, then rotates it once
// through the tail-to-head loop and compares load/readback CRC-16-CCITT.
module ccff_loader #(
    parameter int CHAIN_LEN = 128
) (
    input  logic       prog_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       ccff_head,
    output logic       chain_clk_en,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       pass
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  buf_q, buf_d;
    logic [3:0]  nb_q, nb_d;
    logic [15:0] crc_load_q, crc_load_d, crc_vfy_q, crc_vfy_d;
    logic        pass_q, pass_d;
    logic        last;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        nb_d         = nb_q;
        crc_load_d   = crc_load_q;
        crc_vfy_d    = crc_vfy_q;
        pass_d       = pass_q;
        s_ready      = 1'b0;
        chain_clk_en = 1'b0;
        ccff_head    = 1'b0;
        last         = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d    = LOAD;
                cnt_d      = '0;
                buf_d      = '0;
                nb_d       = '0;
                pass_d     = 1'b0;
                crc_load_d = 16'hFFFF;
                crc_vfy_d  = 16'hFFFF;
            end
            LOAD: begin
                chain_clk_en = nb_q != 4'd0;
                ccff_head    = buf_q[7];
                last         = chain_clk_en && cnt_q == LAST;
                // nb_q==1 implies a shift this cycle, so a new byte can land behind it
                s_ready      = !last && nb_q <= 4'd1;
                if (chain_clk_en) begin
                    buf_d      = {buf_q[6:0], 1'b0};
                    nb_d       = nb_q - 4'd1;
                    cnt_d      = cnt_q + 1'b1;
                    crc_load_d = crc_step(crc_load_q, buf_q[7]);
                end
                if (s_valid && s_ready) begin
                    buf_d = s_data;
                    nb_d  = 4'd8;
                end
                if (last) begin
                    state_d = ROTATE;
                    cnt_d   = '0;
                    buf_d   = '0;
                    nb_d    = '0;
                end
            end
            ROTATE: begin
                chain_clk_en = 1'b1;
                ccff_head    = ccff_tail;
                crc_vfy_d    = crc_step(crc_vfy_q, ccff_tail);
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    pass_d  = crc_load_q == crc_vfy_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            nb_q       <= '0;
            crc_load_q <= '0;
            crc_vfy_q  <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            nb_q       <= nb_d;
            crc_load_q <= crc_load_d;
            crc_vfy_q  <= crc_vfy_d;
            pass_q     <= pass_d;
        end
    end

    assign busy = state_q == LOAD || state_q == ROTATE;
    assign done = state_q == DONE;
    assign pass = pass_q;
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 128, meaning number of configuration flops in the target ccff chain (legal range 1..65535).
REQ-002 SHALL have port prog_clk  input  1  programming clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port s_data  input  8  bitstream byte; bit 7 is shifted first.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  byte accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port ccff_head  output  1  serial data into the chain head.
REQ-009 SHALL have port chain_clk_en  output  1  shift enable; chain flops capture only on prog_clk edges where it is high.
REQ-010 SHALL have port ccff_tail  input  1  serial data from the chain tail.
REQ-011 SHALL have port busy  output  1  high in LOAD and ROTATE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at session end.
REQ-013 SHALL have port pass  output  1  verify result, valid from the done pulse until the next start.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> ROTATE -> DONE -> IDLE.
REQ-015 IDLE: start=1 SHALL go to LOAD and clear the bit counter, byte buffer, pass and both CRCs (CRC init 0xFFFF). start is ignored in every other state.
REQ-016 LOAD: s_ready SHALL be high when the byte buffer is empty, or when it holds its last bit and chain_clk_en=1, so that held s_valid sustains one bit per cycle.
REQ-017 LOAD: chain_clk_en SHALL be 1 exactly when the buffer holds a bit, and ccff_head SHALL be the buffer MSB. Each enabled cycle shifts the buffer left and increments the bit counter.
REQ-018 LOAD: buffer empty (s_valid low) SHALL give chain_clk_en=0 and SHALL NOT advance the counter, which stalls the chain.
REQ-019 When the enabled cycle carries bit CHAIN_LEN-1, the FSM SHALL go to ROTATE next cycle and clear the counter. Unshifted bits of the final byte are discarded, and s_ready SHALL be 0 from that cycle onward.
REQ-020 ROTATE: chain_clk_en SHALL be 1 and ccff_head SHALL equal ccff_tail (combinational loopback) for exactly CHAIN_LEN cycles, which restores the loaded contents.
REQ-021 CRC-16-CCITT (poly 0x1021, bit-serial, MSB-first) crc_load SHALL absorb ccff_head on every enabled LOAD cycle. crc_vfy SHALL absorb ccff_tail on every ROTATE cycle.
REQ-022 After the last ROTATE cycle the FSM SHALL enter DONE for one cycle with done=1 and pass=(crc_load==crc_vfy), then return to IDLE. pass SHALL hold.
REQ-023 Outside LOAD/ROTATE: chain_clk_en=0, ccff_head=0, s_ready=0.
REQ-024 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-025 A byte whose handshake coincides with the final LOAD bit SHALL NOT be accepted.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE and clear counter, buffer, CRCs, s_ready, chain_clk_en, ccff_head, busy, done and pass to 0, independent of prog_clk.
REQ-027 Reset during LOAD or ROTATE SHALL abort the session without a done pulse. Chain contents are then undefined, and the next start restarts from bit 0.

Verification
REQ-028 CHAIN_LEN=16, chain model = 16-flop shift register, bytes 0xA5,0x3C with s_valid held -> 16 consecutive chain_clk_en cycles, chain = 1010010100111100 head-first, then 16 ROTATE cycles, done with pass=1, chain unchanged.
REQ-029 CHAIN_LEN=12, bytes 0xF0,0x0F -> 12 bits loaded (111100000000), last 4 bits of 0x0F discarded, s_ready=0 after the 2nd byte, pass=1.
REQ-030 CHAIN_LEN=16, s_valid dropped for 5 cycles between bytes -> chain_clk_en=0 for those cycles, bit count unaffected, final chain identical to REQ-028.
REQ-031 CHAIN_LEN=16, chain model with one flop stuck-at-0, load 0xFF,0xFF -> done with pass=0.
REQ-032 reset_n pulsed low at LOAD bit 7, then start plus 0xA5,0x3C -> no done before the restart, all outputs 0 during reset, the second session gives pass=1.
REQ-033 start asserted during LOAD and ROTATE -> ignored, and exactly one done pulse per session.
